// File: rtl/multi_mode_flop_reg.sv
// WIDTH-bit register bank with per-cycle selectable D/T/SR/JK flip-flop behaviour
// or shift/rotate operation, plus change-detect and SR-conflict pulses.
module multi_mode_flop_reg #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             changed,
    output logic             sr_err
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_D    = 3'b001,
        MODE_T    = 3'b010,
        MODE_SR   = 3'b011,
        MODE_JK   = 3'b100,
        MODE_SHL  = 3'b101,
        MODE_SHR  = 3'b110,
        MODE_ROL  = 3'b111
    } mode_e;

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q, q_d, q_next;
    logic             ser_out_q, ser_out_d, ser_next;
    logic             changed_q, changed_d;
    logic             sr_err_q, sr_err_d;

    assign mode_s = mode_e'(mode);

    always_comb begin
        q_next   = q_q;
        ser_next = ser_out_q;
        case (mode_s)
            MODE_HOLD: q_next = q_q;
            MODE_D:    q_next = a;
            MODE_T:    q_next = q_q ^ a;
            MODE_SR: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (a[i] && !b[i])      q_next[i] = 1'b1;
                    else if (!a[i] && b[i]) q_next[i] = 1'b0;
                end
            end
            MODE_JK: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    case ({a[i], b[i]})
                        2'b01:   q_next[i] = 1'b0;
                        2'b10:   q_next[i] = 1'b1;
                        2'b11:   q_next[i] = ~q_q[i];
                        default: q_next[i] = q_q[i];
                    endcase
                end
            end
            MODE_SHL: begin
                q_next   = {q_q[WIDTH-2:0], ser_in};
                ser_next = q_q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next   = {ser_in, q_q[WIDTH-1:1]};
                ser_next = q_q[0];
            end
            MODE_ROL: begin
                q_next   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                ser_next = q_q[WIDTH-1];
            end
            default: q_next = q_q;
        endcase
    end

    // With en low the state holds and both pulses drop.
    always_comb begin
        q_d       = en ? q_next : q_q;
        ser_out_d = en ? ser_next : ser_out_q;
        changed_d = en && (q_next != q_q);
        sr_err_d  = en && (mode_s == MODE_SR) && (|(a & b));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q       <= RESET_VAL;
            ser_out_q <= 1'b0;
            changed_q <= 1'b0;
            sr_err_q  <= 1'b0;
        end else begin
            q_q       <= q_d;
            ser_out_q <= ser_out_d;
            changed_q <= changed_d;
            sr_err_q  <= sr_err_d;
        end
    end

    assign q       = q_q;
    assign ser_out = ser_out_q;
    assign changed = changed_q;
    assign sr_err  = sr_err_q;

endmodule

// File: tb/tb_multi_mode_flop_reg.sv
// Bench for multi_mode_flop_reg: directed scenarios followed by random cycles,
// all checked against an arithmetic reference model.
module tb_multi_mode_flop_reg;

    localparam int unsigned W  = 8;
    localparam int          RV = 'hA5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [2:0]   mode = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ser_in = 1'b0;
    logic [W-1:0] q;
    logic         ser_out, changed, sr_err;

    int nvec = 0;
    int nerr = 0;

    // Reference state, kept as plain integers.
    int m_q = 0, m_so = 0, m_ch = 0, m_err = 0;

    multi_mode_flop_reg #(.WIDTH(W), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .ser_in(ser_in), .q(q), .ser_out(ser_out), .changed(changed), .sr_err(sr_err)
    );

    always #5 clk = ~clk;

    task automatic model_step(input int r, input int e, input int m, input int av,
                              input int bv, input int s);
        int nq, qa, ai, bi, top;
        top = 1 << (W - 1);
        if (r == 0) begin
            m_q = RV; m_so = 0; m_ch = 0; m_err = 0;
        end else if (e == 0) begin
            m_ch = 0; m_err = 0;
        end else begin
            nq = m_q;
            case (m)
                1: nq = av;
                2: nq = m_q ^ av;
                3, 4: begin
                    nq = 0;
                    for (int i = 0; i < W; i++) begin
                        qa = (m_q >> i) % 2; ai = (av >> i) % 2; bi = (bv >> i) % 2;
                        if (ai == 1 && bi == 0) qa = 1;
                        else if (ai == 0 && bi == 1) qa = 0;
                        else if (ai == 1 && bi == 1 && m == 4) qa = 1 - qa;
                        nq = nq + qa * (1 << i);
                    end
                end
                5: begin nq = (m_q * 2 + s) % (2 * top); m_so = m_q / top; end
                6: begin nq = m_q / 2 + s * top; m_so = m_q % 2; end
                7: begin nq = (m_q * 2) % (2 * top) + m_q / top; m_so = m_q / top; end
                default: nq = m_q;
            endcase
            m_ch  = (nq != m_q) ? 1 : 0;
            m_err = (m == 3 && (av & bv) != 0) ? 1 : 0;
            m_q   = nq;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance model and DUT, then compare all outputs.
    task automatic cyc(input int r, input int e, input int m, input int av, input int bv,
                       input int s, input string tag);
        rst = r[0]; en = e[0]; mode = m[2:0]; a = av[W-1:0]; b = bv[W-1:0]; ser_in = s[0];
        @(posedge clk);
        model_step(r, e, m, av, bv, s);
        #1;
        check({tag, ".q"},       32'(q),       32'(m_q));
        check({tag, ".ser_out"}, 32'(ser_out), 32'(m_so));
        check({tag, ".changed"}, 32'(changed), 32'(m_ch));
        check({tag, ".sr_err"},  32'(sr_err),  32'(m_err));
    endtask

    initial begin
        // Reset held for two edges, then a D write that reset must still override.
        cyc(0, 0, 0, 0, 0, 0, "rst1");
        cyc(0, 0, 0, 0, 0, 0, "rst2");
        check("rst_q_const", 32'(q), 32'hA5);
        cyc(0, 1, 1, 'h3C, 0, 0, "rst_over_d");
        check("rst_over_d_const", 32'(q), 32'hA5);

        // D mode and clock enable.
        cyc(1, 1, 1, 'h00, 0, 0, "d_zero");
        cyc(1, 1, 1, 'h3C, 0, 0, "d_3c");
        check("d_3c_changed", 32'(changed), 32'd1);
        cyc(1, 1, 1, 'h3C, 0, 0, "d_repeat");
        check("d_repeat_changed", 32'(changed), 32'd0);
        cyc(1, 0, 1, 'hFF, 0, 0, "en_off");
        check("en_off_q", 32'(q), 32'h3C);

        // T then JK set/clear then JK toggle.
        cyc(1, 1, 2, 'hFF, 0, 0, "t_ff");
        check("t_ff_q", 32'(q), 32'hC3);
        cyc(1, 1, 4, 'hF0, 'h0F, 0, "jk_sc");
        check("jk_sc_q", 32'(q), 32'hF0);
        cyc(1, 1, 4, 'hFF, 'hFF, 0, "jk_tog");
        check("jk_tog_q", 32'(q), 32'h0F);

        // SR with a conflicting bit, then HOLD clears the pulse.
        cyc(1, 1, 3, 'h81, 'h01, 0, "sr_conf");
        check("sr_conf_q", 32'(q), 32'h8F);
        check("sr_conf_err", 32'(sr_err), 32'd1);
        cyc(1, 1, 0, 0, 0, 0, "hold");
        check("hold_err", 32'(sr_err), 32'd0);

        // Shift left/right, then eight rotates return the start value.
        cyc(1, 1, 1, 'h80, 0, 0, "load80");
        cyc(1, 1, 5, 0, 0, 1, "shl");
        check("shl_q", 32'(q), 32'h01);
        cyc(1, 1, 6, 0, 0, 0, "shr");
        check("shr_so", 32'(ser_out), 32'd1);
        cyc(1, 1, 1, 'h81, 0, 0, "load81");
        for (int i = 0; i < 8; i++) cyc(1, 1, 7, 0, 0, 0, "rol");
        check("rol8_q", 32'(q), 32'h81);

        // Reset lands inside a shift burst; no leftover pulse, no resumption.
        cyc(1, 1, 1, 'h0F, 0, 0, "load0f");
        cyc(1, 1, 5, 0, 0, 1, "burst1");
        cyc(1, 1, 5, 0, 0, 1, "burst2");
        cyc(0, 1, 5, 0, 0, 1, "burst_rst");
        cyc(1, 1, 0, 0, 0, 0, "post_rst");
        check("post_rst_q", 32'(q), 32'hA5);

        // Random traffic with occasional reset and enable drops.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 31) == 0) ? 0 : 1,
                ($urandom_range(0, 5) == 0) ? 0 : 1,
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
